// File: rtl/button_event_arbiter.sv
// Round-robin arbiter turning per-button event pulses into a valid/ready ID stream.
// Optional saturating drop counter enabled by defining BTN_OVF_CNT_EN.
module button_event_arbiter #(
  parameter int N_CH  = 4,
  parameter int ID_W  = 2,
  parameter int OVF_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_pulse,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [ID_W-1:0] evt_id,
  output logic [N_CH-1:0] pending,
  output logic            ovf_pulse
`ifdef BTN_OVF_CNT_EN
  ,
  output logic [OVF_W-1:0] ovf_count,
  input  logic             ovf_clr
`endif
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [N_CH-1:0] pending_q, pending_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] evt_id_q, evt_id_d;
  logic            ovf_pulse_q, ovf_pulse_d;

  logic            grant;
  logic [ID_W-1:0] sel;
  logic [ID_W-1:0] hi_sel, lo_sel;
  logic            hi_found, lo_found;
  logic [N_CH-1:0] gnt_oh;
  logic [N_CH-1:0] drop_vec;

  // Lowest pending index at/after rr_ptr wins; otherwise wrap to the lowest overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_sel   = '0;
    lo_sel   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        lo_found = 1'b1;
        lo_sel   = ID_W'(i);
        if (ID_W'(i) >= rr_ptr_q) begin
          hi_found = 1'b1;
          hi_sel   = ID_W'(i);
        end
      end
    end
    sel   = hi_found ? hi_sel : lo_sel;
    grant = (state_q == IDLE) && lo_found;
  end

  always_comb begin
    gnt_oh = '0;
    for (int i = 0; i < N_CH; i++) begin
      gnt_oh[i] = grant && (sel == ID_W'(i));
    end
    drop_vec  = btn_pulse & pending_q & ~gnt_oh;
    pending_d = btn_pulse | (pending_q & ~gnt_oh);
    ovf_pulse_d = |drop_vec;
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    evt_id_d = evt_id_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d  = PRESENT;
          evt_id_d = sel;
        end
      end
      PRESENT: begin
        if (evt_ready) begin
          state_d  = IDLE;
          rr_ptr_d = (evt_id_q == ID_W'(N_CH - 1)) ? '0
                                                   : evt_id_q + ID_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      rr_ptr_q    <= '0;
      evt_id_q    <= '0;
      ovf_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      rr_ptr_q    <= rr_ptr_d;
      evt_id_q    <= evt_id_d;
      ovf_pulse_q <= ovf_pulse_d;
    end
  end

  assign evt_valid = (state_q == PRESENT);
  assign evt_id    = evt_id_q;
  assign pending   = pending_q;
  assign ovf_pulse = ovf_pulse_q;

`ifdef BTN_OVF_CNT_EN
  logic [OVF_W-1:0] ovf_count_q, ovf_count_d;

  // Counts alongside ovf_pulse so a clear in a drop cycle leaves zero.
  always_comb begin
    ovf_count_d = ovf_count_q;
    if (ovf_clr) begin
      ovf_count_d = '0;
    end else if (ovf_pulse_d && (ovf_count_q != '1)) begin
      ovf_count_d = ovf_count_q + OVF_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_count_q <= '0;
    end else begin
      ovf_count_q <= ovf_count_d;
    end
  end

  assign ovf_count = ovf_count_q;
`endif

endmodule

// File: tb/tb_button_event_arbiter.sv
// Randomised and directed checks of button_event_arbiter against a behavioural model.
// Covers the optional counter when BTN_OVF_CNT_EN is defined.
module tb_button_event_arbiter;
  localparam int N     = 4;
  localparam int IW    = 2;
  localparam int OW    = 2;
  localparam int OMAX  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  btn_pulse;
  logic          evt_valid;
  logic          evt_ready;
  logic [IW-1:0] evt_id;
  logic [N-1:0]  pending;
  logic          ovf_pulse;
`ifdef BTN_OVF_CNT_EN
  logic [OW-1:0] ovf_count;
  logic          ovf_clr;
`endif

  int total = 0;
  int bad   = 0;

  bit m_pend[N];
  bit m_valid;
  int m_id;
  int m_rr;
  bit m_ovf;
  int m_cnt;
  bit clr_in;

  button_event_arbiter #(.N_CH(N), .ID_W(IW), .OVF_W(OW)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_pulse (btn_pulse),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_id    (evt_id),
    .pending   (pending),
    .ovf_pulse (ovf_pulse)
`ifdef BTN_OVF_CNT_EN
    ,
    .ovf_count (ovf_count),
    .ovf_clr   (ovf_clr)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] m_pend_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
    m_valid = 1'b0;
    m_id    = 0;
    m_rr    = 0;
    m_ovf   = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] p, input logic r,
                            input bit clr);
    int  g;
    bit  drop;
    g = -1;
    if (!m_valid) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_rr + k) % N;
        if (g < 0 && m_pend[c]) g = c;
      end
    end
    drop = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (p[i] && m_pend[i] && i != g) drop = 1'b1;
      m_pend[i] = p[i] || (m_pend[i] && i != g);
    end
    if (g >= 0) begin
      m_valid = 1'b1;
      m_id    = g;
    end else if (m_valid && r) begin
      m_valid = 1'b0;
      m_rr    = (m_id + 1) % N;
    end
    m_ovf = drop;
    if (clr) m_cnt = 0;
    else if (drop && m_cnt < OMAX) m_cnt++;
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_valid"}, 32'(evt_valid), 32'(m_valid));
    check({tag, "_id"}, 32'(evt_id), 32'(m_id));
    check({tag, "_pend"}, 32'(pending), 32'(m_pend_vec()));
    check({tag, "_ovf"}, 32'(ovf_pulse), 32'(m_ovf));
`ifdef BTN_OVF_CNT_EN
    check({tag, "_cnt"}, 32'(ovf_count), 32'(m_cnt));
`endif
  endtask

  task automatic step(input logic [N-1:0] p, input logic r, input bit clr,
                      input string tag);
    btn_pulse = p;
    evt_ready = r;
    clr_in    = clr;
`ifdef BTN_OVF_CNT_EN
    ovf_clr = clr;
`endif
    @(posedge clk);
    model_edge(p, r, clr);
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    btn_pulse = '0;
    evt_ready = 1'b0;
    clr_in    = 1'b0;
`ifdef BTN_OVF_CNT_EN
    ovf_clr = 1'b0;
`endif
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    compare_all("rst");

    // single event, latency two edges, one presented cycle
    step(4'b0000, 1'b1, 1'b0, "t2_idle");
    step(4'b0100, 1'b1, 1'b0, "t2_pulse");
    check("t2_pend_set", 32'(pending), 32'h4);
    check("t2_not_yet", 32'(evt_valid), 32'h0);
    step(4'b0000, 1'b1, 1'b0, "t2_grant");
    check("t2_valid", 32'(evt_valid), 32'h1);
    check("t2_id", 32'(evt_id), 32'h2);
    check("t2_pend_clr", 32'(pending), 32'h0);
    step(4'b0000, 1'b1, 1'b0, "t2_after");
    check("t2_valid_off", 32'(evt_valid), 32'h0);

    // round-robin over 0,1,3 with one bubble between events
    do_reset();
    step(4'b1011, 1'b1, 1'b0, "t3_pulse");
    for (int i = 0; i < 7; i++) step(4'b0000, 1'b1, 1'b0, "t3");
    check("t3_empty", 32'(pending), 32'h0);

    // back-pressure with repeated pulses on a pending channel
    do_reset();
    step(4'b0010, 1'b0, 1'b0, "t4_a");
    step(4'b0000, 1'b0, 1'b0, "t4_b");
    step(4'b0010, 1'b0, 1'b0, "t4_c");
    step(4'b0010, 1'b0, 1'b0, "t4_d");
    check("t4_ovf", 32'(ovf_pulse), 32'h1);
    step(4'b0000, 1'b0, 1'b0, "t4_e");
    check("t4_ovf_once", 32'(ovf_pulse), 32'h0);
    check("t4_id_stable", 32'(evt_id), 32'h1);
    for (int i = 0; i < 4; i++) step(4'b0000, 1'b1, 1'b0, "t4_drain");

    // set wins over grant-clear, not an overflow
    do_reset();
    step(4'b0001, 1'b0, 1'b0, "t5_a");
    step(4'b0001, 1'b0, 1'b0, "t5_grant");
    check("t5_no_ovf", 32'(ovf_pulse), 32'h0);
    check("t5_pend", 32'(pending), 32'h1);
    for (int i = 0; i < 4; i++) step(4'b0000, 1'b1, 1'b0, "t5_drain");

`ifdef BTN_OVF_CNT_EN
    do_reset();
    step(4'b0100, 1'b0, 1'b0, "t6_fill");
    step(4'b0000, 1'b0, 1'b0, "t6_gnt");
    step(4'b0100, 1'b0, 1'b0, "t6_pend");
    for (int i = 0; i < 5; i++) step(4'b0100, 1'b0, 1'b0, "t6_drop");
    check("t6_sat", 32'(ovf_count), 32'h3);
    step(4'b0100, 1'b0, 1'b1, "t6_clr");
    check("t6_cleared", 32'(ovf_count), 32'h0);
`endif

    // randomised traffic
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic [N-1:0] p;
      for (int i = 0; i < N; i++) p[i] = ($urandom_range(3) == 0);
      step(p, 1'($urandom_range(1)), ($urandom_range(7) == 0), "rnd");
    end

    // asynchronous reset while an event is presented
    step(4'b1111, 1'b0, 1'b0, "t1_fill");
    step(4'b0000, 1'b0, 1'b0, "t1_present");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all("t1_async");
    @(negedge clk);
    rst = 1'b0;
    step(4'b0000, 1'b1, 1'b0, "t1_post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
